// File: rtl/jk_sync_counter_if.sv
// Control and observation bundle for jk_sync_counter.
// The counter is the slave; the driving logic is the master.
interface jk_sync_counter_if #(
  parameter int unsigned WIDTH = 4
);
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qbar;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic             tc;
  logic             wrap;
  logic             err;

  modport master (
    output en, up, load, d,
    input  q, qbar, j, k, tc, wrap, err
  );

  modport slave (
    input  en, up, load, d,
    output q, qbar, j, k, tc, wrap, err
  );
endinterface

// File: rtl/jk_sync_counter.sv
// Modulo-MODULUS up/down counter whose state advances only through per-bit JK excitation.
// Provides parallel load, terminal-count lookahead, a registered wrap pulse and a sticky load error.
module jk_sync_counter #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MODULUS = 10
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  jk_sync_counter_if.slave     bus_io
);

  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   ModExt = (WIDTH + 1)'(MODULUS);

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] n;
  logic [WIDTH-1:0] j, k;
  logic             wrap_q;
  logic             err_q, err_d;
  logic             at_max, at_zero, d_ok, tc;

  assign at_max  = (q_q == MaxVal);
  assign at_zero = (q_q == '0);
  assign d_ok    = ({1'b0, bus_io.d} < ModExt);

  always_comb begin
    n     = q_q;
    err_d = err_q;
    if (bus_io.load) begin
      if (d_ok) begin
        n     = bus_io.d;
        err_d = 1'b0;
      end else begin
        n     = '0;
        err_d = 1'b1;
      end
    end else if (bus_io.en) begin
      if (bus_io.up) begin
        n = at_max ? '0 : q_q + 1'b1;
      end else begin
        n = at_zero ? MaxVal : q_q - 1'b1;
      end
    end
  end

  assign j  = ~q_q & n;
  assign k  = q_q & ~n;
  // Characteristic JK equation: set on J, keep unless K; J=K=1 toggles.
  assign q_d = (j & ~q_q) | (~k & q_q);

  assign tc = bus_io.en & ~bus_io.load &
              ((bus_io.up & at_max) | (~bus_io.up & at_zero));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q    <= '0;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= tc;
      err_q  <= err_d;
    end
  end

  assign bus_io.q    = q_q;
  assign bus_io.qbar = ~q_q;
  assign bus_io.j    = j;
  assign bus_io.k    = k;
  assign bus_io.tc   = tc;
  assign bus_io.wrap = wrap_q;
  assign bus_io.err  = err_q;

endmodule
